id_scoreboard: RTL

//  Issue controller for the decode stage. Tracks writes to architectural registers that are
//  in flight between ID issue and WB retire. Stalls ID on read-after-write hazards, on counter

---
 rtl/id_scoreboard_pkg.sv | 14 +
 rtl/sb_counter_bank.sv | 46 ++++
 rtl/id_scoreboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the decode-stage issue scoreboard.
// Holds the register address width and the fence FSM state encodings.
// Imported by id_scoreboard and sb_counter_bank.
package id_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters (NREGS x CNT_W), one inc and one dec port.
// Latency: counter updates visible one cycle after inc/dec/clear.
// Backpressure: none; the caller never increments a saturated or decrements an empty counter.
module sb_counter_bank
  import id_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [REG_ADDR_W-1:0] inc_addr,
  input  logic                  dec,
  input  logic [REG_ADDR_W-1:0] dec_addr,
  input  logic                  clear,
  output logic [NREGS-1:0]      nonzero,
  output logic [NREGS-1:0]      sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             inc_hit;
    logic             dec_hit;

    assign inc_hit = inc && (inc_addr == REG_ADDR_W'(g));
    assign dec_hit = dec && (dec_addr == REG_ADDR_W'(g));

    // A simultaneous inc and dec to the same register cancel out.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        cnt_q <= '0;
      end else if (inc_hit && !dec_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec_hit && !inc_hit) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    assign nonzero[g] = (cnt_q != '0);
    assign sat[g]     = (cnt_q == CNT_MAX);
  end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage issue controller: RAW/saturation/full stalls plus fence drain.
// Latency: idStall/idIssue combinational from registered state; counters update next cycle.
// Backpressure: ID is held via idStall while exReady is low, on hazards, or while draining.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter  int NREGS        = 32,
  parameter  int CNT_W        = 2,
  parameter  int MAX_INFLIGHT = 4,
  localparam int INF_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  input  logic                  rs1ReadEnable,
  input  logic [REG_ADDR_W-1:0] rs1ReadAddr,
  input  logic                  rs2ReadEnable,
  input  logic [REG_ADDR_W-1:0] rs2ReadAddr,
  input  logic                  rdWriteEnable,
  input  logic [REG_ADDR_W-1:0] rdWriteAddr,
  input  logic                  exReady,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbAddr,
  input  logic                  flush,
  input  logic                  fenceReq,
  output logic                  idStall,
  output logic                  idIssue,
  output logic                  fenceDone,
  output logic [INF_W-1:0]      inflightCnt
);

  sb_state_t        state;
  sb_state_t        state_nxt;
  logic [NREGS-1:0] reg_nonzero;
  logic [NREGS-1:0] reg_sat;
  logic             hazard;
  logic             sat_hit;
  logic             full;
  logic             in_run;
  logic             track;
  logic             retire;

  sb_counter_bank #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .inc      (track),
    .inc_addr (rdWriteAddr),
    .dec      (retire),
    .dec_addr (wbAddr),
    .clear    (flush),
    .nonzero  (reg_nonzero),
    .sat      (reg_sat)
  );

  // Stall decision from registered state only; a same-cycle WB does not unblock a reader.
  always_comb begin
    hazard  = (rs1ReadEnable && (rs1ReadAddr != '0) && reg_nonzero[rs1ReadAddr])
           || (rs2ReadEnable && (rs2ReadAddr != '0) && reg_nonzero[rs2ReadAddr]);
    sat_hit = rdWriteEnable && (rdWriteAddr != '0) && reg_sat[rdWriteAddr];
    full    = (inflightCnt == INF_W'(MAX_INFLIGHT));
    idStall = idValid && (hazard || sat_hit || full || !in_run || !exReady);
    idIssue = idValid && !idStall;
    track   = idIssue && rdWriteEnable && (rdWriteAddr != '0);
    retire  = wbValid && (wbAddr != '0) && reg_nonzero[wbAddr];
  end

  // Outstanding-write count; track and retire in the same cycle leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflightCnt <= '0;
    end else if (track && !retire) begin
      inflightCnt <= inflightCnt + INF_W'(1);
    end else if (retire && !track) begin
      inflightCnt <= inflightCnt - INF_W'(1);
    end
  end

  // Fence FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SB_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Fence FSM next state. An already-empty pipeline skips DRAIN, unless the entering
  // cycle itself issues a tracked write that must still be waited for.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = SB_RUN;
    end else begin
      unique case (state)
        SB_RUN: begin
          if (fenceReq) begin
            state_nxt = ((inflightCnt == '0) && !track) ? SB_DONE : SB_DRAIN;
          end
        end
        SB_DRAIN: begin
          if (inflightCnt == '0) begin
            state_nxt = SB_DONE;
          end
        end
        SB_DONE:  state_nxt = SB_RUN;
        default:  state_nxt = SB_RUN;
      endcase
    end
  end

  // Fence FSM outputs: issue only in RUN, one-cycle completion pulse in DONE.
  always_comb begin
    in_run    = (state == SB_RUN);
    fenceDone = (state == SB_DONE);
  end

endmodule
